alu_64: RTL and testbench

ALU_64 -- requirements
Module: alu_64

---
 rtl/alu_64.sv | 175 +++++++++++++++++
 tb/tb_alu_64.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_64.sv
// 64-bit registered ALU: pass-B, add, subtract, AND, OR and XOR.
// The adder is a ripple chain of full adders. A 5:1 mux on each bit picks
// the result. Every output, including the N/Z/V/C flags, is registered.
// An active-high asynchronous reset clears the registers.

// One-bit full adder, the cell of the ripple-carry chain.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// Per-bit 5:1 result mux.
// Index 0 = B, 1 = add, 2 = and, 3 = or, 4 = xor.
// Select codes 5..7 drive 0, which gives the reserved opcodes their zero
// result.
module mux5_1 (
    input  logic [4:0] d,
    input  logic [2:0] sel,
    output logic       y
);

    // AND-OR selection with a one-hot decode of sel
    always_comb begin
        y = (d[0] & (sel == 3'd0)) |
            (d[1] & (sel == 3'd1)) |
            (d[2] & (sel == 3'd2)) |
            (d[3] & (sel == 3'd3)) |
            (d[4] & (sel == 3'd4));
    end

endmodule

module alu_64 #(
    // Gate propagation delay in ps, used for back-annotated timing runs.
    // It has no functional effect in this RTL.
    parameter int DELAY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [2:0]  cntrl,
    output logic [63:0] result,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry_out
);

    // Datapath width. The DELAY term is always zero; it only keeps the
    // timing-annotation parameter attached to the design.
    localparam int N = 64 + 0 * DELAY;

    logic [63:0] b_op;
    logic [63:0] sum;
    logic [63:0] carry;
    logic [63:0] and_v;
    logic [63:0] or_v;
    logic [63:0] xor_v;
    logic [63:0] res_next;
    logic [2:0]  mux_sel;
    logic        zero_next;
    logic        ovf_next;
    logic        cout_next;

    // Balanced OR-reduction tree levels for the zero flag
    logic [31:0] or_l1;
    logic [15:0] or_l2;
    logic [7:0]  or_l3;
    logic [3:0]  or_l4;
    logic [1:0]  or_l5;
    logic        or_l6;

    // Subtract is A + ~B + 1. Bit 0 of cntrl both inverts B and supplies
    // the carry-in.
    assign b_op  = B ^ {64{cntrl[0]}};
    assign and_v = A & B;
    assign or_v  = A | B;
    assign xor_v = A ^ B;

    // Ripple-carry adder chain
    for (genvar i = 0; i < N; i++) begin : g_add
        if (i == 0) begin : g_lsb
            fa u_fa (
                .a    (A[i]),
                .b    (b_op[i]),
                .cin  (cntrl[0]),
                .sum  (sum[i]),
                .cout (carry[i])
            );
        end else begin : g_bit
            fa u_fa (
                .a    (A[i]),
                .b    (b_op[i]),
                .cin  (carry[i-1]),
                .sum  (sum[i]),
                .cout (carry[i])
            );
        end
    end

    // Map the opcode to a mux index. Reserved opcodes select an empty slot.
    always_comb begin
        case (cntrl)
            3'b000:         mux_sel = 3'd0;
            3'b010, 3'b011: mux_sel = 3'd1;
            3'b100:         mux_sel = 3'd2;
            3'b101:         mux_sel = 3'd3;
            3'b110:         mux_sel = 3'd4;
            default:        mux_sel = 3'd7;
        endcase
    end

    // Per-bit result selection
    for (genvar i = 0; i < N; i++) begin : g_mux
        mux5_1 u_mux (
            .d   ({xor_v[i], or_v[i], and_v[i], sum[i], B[i]}),
            .sel (mux_sel),
            .y   (res_next[i])
        );
    end

    // Zero detect: six OR levels, then a final NOR
    for (genvar i = 0; i < 32; i++) begin : g_or1
        assign or_l1[i] = res_next[2*i] | res_next[2*i+1];
    end
    for (genvar i = 0; i < 16; i++) begin : g_or2
        assign or_l2[i] = or_l1[2*i] | or_l1[2*i+1];
    end
    for (genvar i = 0; i < 8; i++) begin : g_or3
        assign or_l3[i] = or_l2[2*i] | or_l2[2*i+1];
    end
    for (genvar i = 0; i < 4; i++) begin : g_or4
        assign or_l4[i] = or_l3[2*i] | or_l3[2*i+1];
    end
    for (genvar i = 0; i < 2; i++) begin : g_or5
        assign or_l5[i] = or_l4[2*i] | or_l4[2*i+1];
    end
    assign or_l6     = or_l5[0] | or_l5[1];
    assign zero_next = ~or_l6;

    // The adder flags are produced for every opcode. They are only
    // meaningful when cntrl selects add or subtract.
    assign cout_next = carry[63];
    assign ovf_next  = carry[63] ^ carry[62];

    // Output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= 64'd0;
            negative  <= 1'b0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            result    <= res_next;
            negative  <= res_next[63];
            zero      <= zero_next;
            overflow  <= ovf_next;
            carry_out <= cout_next;
        end
    end

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64.
// A behavioural model is built from plain 65-bit arithmetic, and a compare
// process checks the DUT against it on every falling edge. Directed vectors
// check both the DUT and the model against hand-computed constants. Random
// traffic is interrupted by asynchronous reset pulses.
module tb_alu_64;

    logic        clk;
    logic        reset;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic [63:0] r;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } exp_t;

    exp_t exp_q;

    alu_64 #(.DELAY(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour. The operation is computed from its arithmetic
    // definition; the flags come from 65-bit sums and sign rules.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] op);
        exp_t        e;
        logic [63:0] bx;
        logic [64:0] s;
        bx  = op[0] ? ~b : b;
        s   = {1'b0, a} + {1'b0, bx} + {64'd0, op[0]};
        e.c = s[64];
        e.v = (a[63] == bx[63]) && (s[63] != a[63]);
        case (op)
            3'b000:  e.r = b;
            3'b010:  e.r = a + b;
            3'b011:  e.r = a - b;
            3'b100:  e.r = a & b;
            3'b101:  e.r = a | b;
            3'b110:  e.r = a ^ b;
            default: e.r = 64'd0;
        endcase
        e.n = e.r[63];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    function automatic exp_t reset_vals();
        exp_t e;
        e.r = 64'd0; e.n = 1'b0; e.z = 1'b1; e.v = 1'b0; e.c = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".result"},    result,           e.r);
        chk({tag, ".negative"},  {63'd0, negative}, {63'd0, e.n});
        chk({tag, ".zero"},      {63'd0, zero},     {63'd0, e.z});
        chk({tag, ".overflow"},  {63'd0, overflow}, {63'd0, e.v});
        chk({tag, ".carry_out"}, {63'd0, carry_out}, {63'd0, e.c});
    endtask

    // Expected registered state: follows the clock, cleared by reset
    always @(posedge clk or posedge reset) begin
        if (reset) exp_q = reset_vals();
        else       exp_q = model(A, B, cntrl);
    end

    // Compare process: the outputs are stable at every falling edge
    always @(negedge clk) begin
        chk_all("cycle", exp_q);
    end

    // Directed vector. The DUT and the model are both held against
    // literal expectations one cycle after the inputs are sampled.
    task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] op, input logic [63:0] r,
                            input logic n, input logic z, input logic v, input logic c,
                            input logic check_flags);
        exp_t lit;
        exp_t m;
        @(negedge clk);
        A = a; B = b; cntrl = op;
        @(posedge clk);
        #1;
        lit.r = r; lit.n = n; lit.z = z; lit.v = v; lit.c = c;
        m = model(a, b, op);
        chk({tag, ".dut_result"}, result, r);
        chk({tag, ".model_result"}, m.r, r);
        chk({tag, ".dut_n"}, {63'd0, negative}, {63'd0, n});
        chk({tag, ".dut_z"}, {63'd0, zero}, {63'd0, z});
        chk({tag, ".model_nz"}, {62'd0, m.n, m.z}, {62'd0, n, z});
        if (check_flags) begin
            chk({tag, ".dut_vc"}, {62'd0, overflow, carry_out}, {62'd0, lit.v, lit.c});
            chk({tag, ".model_vc"}, {62'd0, m.v, m.c}, {62'd0, lit.v, lit.c});
        end
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            3:       v = 64'h8000_0000_0000_0000;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        A        = 64'h1234;
        B        = 64'h5678;
        cntrl    = 3'b010;
        exp_q    = reset_vals();

        // Reset state holds across clock edges while reset stays asserted
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_hold", reset_vals());

        // The first edge after deassertion captures the inputs at that edge
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge.result", result, 64'h0000_0000_0000_68AC);

        directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010,
                 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        directed("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010,
                 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        directed("sub_eq", 64'd5, 64'd5, 3'b011,
                 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        directed("sub_neg", 64'd0, 64'd1, 3'b011,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("and", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b100,
                 64'hF000_F000_F000_F000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("or", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b101,
                 64'hFFF0_FFF0_FFF0_FFF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("xor", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b110,
                 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("passb", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b000,
                 64'hFF00_FF00_FF00_FF00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("rsv001", 64'h1234, 64'h1234, 3'b001,
                 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        directed("rsv111", 64'h1234, 64'h1234, 3'b111,
                 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back random operations with occasional reset pulses
        // between clock edges
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            A     = rand_operand();
            B     = rand_operand();
            cntrl = 3'($urandom_range(0, 7));
            if (i % 97 == 50) begin
                @(posedge clk);
                #3;
                reset = 1'b1;
                #1;
                chk_all("async_reset", reset_vals());
                @(posedge clk);
                #2;
                reset = 1'b0;
            end
        end

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
